// File: rtl/hazard_unit_pkg.sv
// Shared core definitions for the hazard unit: FSM encodings, pipe entry layout, entry ops.
// No logic beyond a pure helper for the forwarding address of an entry.
package hazard_unit_pkg;

  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_BUSY   = 2'd2,
    ST_FLUSH  = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic      vld;
    reg_addr_t rd;
    logic      we;
    logic      load;
  } hz_entry_t;

  typedef enum logic [1:0] {
    ENT_HOLD  = 2'd0,
    ENT_LOAD  = 2'd1,
    ENT_CLEAR = 2'd2
  } ent_op_t;

  // x0 is never a real producer, so it never yields a forwarding address
  function automatic reg_addr_t fwd_addr(input hz_entry_t e);
    return (e.vld && e.we) ? e.rd : '0;
  endfunction

endpackage

// File: rtl/hazard_entry.sv
// One shadow-pipe entry with load / hold / clear control.
// Latency: 1 cycle (registered). No backpressure; the op input decides every cycle.
module hazard_entry
  import hazard_unit_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_in,
  input  ent_op_t   op_in,
  input  hz_entry_t d_in,
  output hz_entry_t q_out
);

  hz_entry_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    case (op_in)
      ENT_LOAD:  q_d = d_in;
      ENT_CLEAR: q_d = '0;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_out = q_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use / busy stalls, flush bubbles, shadow RDs for forwarding.
// Stall and bubble outputs are combinational (0 cycles); shadow pipe and FSM update next edge.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        id_valid_in,
  input  logic [4:0]  id_rs1_addr_in,
  input  logic [4:0]  id_rs2_addr_in,
  input  logic        id_rs1_used_in,
  input  logic        id_rs2_used_in,
  input  logic [4:0]  id_rd_addr_in,
  input  logic        id_rd_we_in,
  input  logic        id_is_load_in,
  input  logic        ex_busy_in,
  input  logic        flush_in,
  output logic        pc_stall_out,
  output logic        id_stall_out,
  output logic        is_bubble_out,
  output logic [4:0]  fwd_rd1_addr_out,
  output logic [4:0]  fwd_rd2_addr_out,
  output logic [4:0]  fwd_rd3_addr_out,
  output logic [1:0]  state_out,
  output logic [15:0] stall_cnt_out
);

  hz_entry_t is_e, ex_e, wb_e, id_e;
  ent_op_t   is_op, ex_op, wb_op;
  hz_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic load_use;

  assign id_e = '{vld: id_valid_in, rd: id_rd_addr_in, we: id_rd_we_in, load: id_is_load_in};

  assign load_use = id_valid_in && is_e.vld && is_e.load && is_e.we && (is_e.rd != '0) &&
                    ((id_rs1_used_in && (id_rs1_addr_in == is_e.rd)) ||
                     (id_rs2_used_in && (id_rs2_addr_in == is_e.rd)));

  hazard_entry u_is (.clk_in(clk_in), .rst_in(rst_in), .op_in(is_op), .d_in(id_e), .q_out(is_e));
  hazard_entry u_ex (.clk_in(clk_in), .rst_in(rst_in), .op_in(ex_op), .d_in(is_e), .q_out(ex_e));
  hazard_entry u_wb (.clk_in(clk_in), .rst_in(rst_in), .op_in(wb_op), .d_in(ex_e), .q_out(wb_e));

  always_comb begin
    state_d       = ST_RUN;
    is_op         = ENT_LOAD;
    ex_op         = ENT_LOAD;
    wb_op         = ENT_LOAD;
    pc_stall_out  = 1'b0;
    id_stall_out  = 1'b0;
    is_bubble_out = 1'b0;
    // Flush wins from any state, including LSTALL and BUSY
    if (flush_in) begin
      state_d       = ST_FLUSH;
      is_op         = ENT_CLEAR;
      ex_op         = ENT_CLEAR;
      is_bubble_out = 1'b1;
    end else if (ex_busy_in) begin
      state_d      = ST_BUSY;
      is_op        = ENT_HOLD;
      ex_op        = ENT_HOLD;
      wb_op        = ENT_CLEAR;
      pc_stall_out = 1'b1;
      id_stall_out = 1'b1;
    end else if (load_use) begin
      state_d       = ST_LSTALL;
      is_op         = ENT_CLEAR;
      pc_stall_out  = 1'b1;
      id_stall_out  = 1'b1;
      is_bubble_out = 1'b1;
    end
    if (rst_in) begin
      pc_stall_out  = 1'b0;
      id_stall_out  = 1'b0;
      is_bubble_out = 1'b0;
    end
  end

  assign cnt_d = (id_stall_out && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_rd1_addr_out = fwd_addr(is_e);
  assign fwd_rd2_addr_out = fwd_addr(ex_e);
  assign fwd_rd3_addr_out = fwd_addr(wb_e);
  assign state_out        = state_q;
  assign stall_cnt_out    = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed vectors push expected outputs, a negedge monitor compares.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, we, ld, busy, flush;
  logic        pc_stall, id_stall, bubble;
  logic [4:0]  f1, f2, f3;
  logic [1:0]  st;
  logic [15:0] cnt;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk_in(clk), .rst_in(rst), .id_valid_in(id_valid),
    .id_rs1_addr_in(rs1), .id_rs2_addr_in(rs2),
    .id_rs1_used_in(u1), .id_rs2_used_in(u2),
    .id_rd_addr_in(rd), .id_rd_we_in(we), .id_is_load_in(ld),
    .ex_busy_in(busy), .flush_in(flush),
    .pc_stall_out(pc_stall), .id_stall_out(id_stall), .is_bubble_out(bubble),
    .fwd_rd1_addr_out(f1), .fwd_rd2_addr_out(f2), .fwd_rd3_addr_out(f3),
    .state_out(st), .stall_cnt_out(cnt)
  );

  typedef struct packed {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic we; logic ld; logic busy; logic flush; logic rst;
  } stim_t;

  typedef struct {
    string tag;
    logic pcs; logic ids; logic bub;
    logic [4:0] f1; logic [4:0] f2; logic [4:0] f3;
    logic [1:0] st; logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  function automatic stim_t S(input int v, input int a1, input int e1, input int a2, input int e2,
                              input int d, input int w, input int l, input int b, input int f,
                              input int r);
    stim_t s;
    s.v = 1'(v); s.rs1 = 5'(a1); s.u1 = 1'(e1); s.rs2 = 5'(a2); s.u2 = 1'(e2);
    s.rd = 5'(d); s.we = 1'(w); s.ld = 1'(l); s.busy = 1'(b); s.flush = 1'(f); s.rst = 1'(r);
    return s;
  endfunction

  function automatic exp_t E(input string tag, input int p, input int i, input int b,
                             input int a1, input int a2, input int a3, input int s, input int c);
    exp_t e;
    e.tag = tag; e.pcs = 1'(p); e.ids = 1'(i); e.bub = 1'(b);
    e.f1 = 5'(a1); e.f2 = 5'(a2); e.f3 = 5'(a3); e.st = 2'(s); e.cnt = 16'(c);
    return e;
  endfunction

  task automatic drive(input stim_t s);
    id_valid = s.v; rs1 = s.rs1; u1 = s.u1; rs2 = s.rs2; u2 = s.u2;
    rd = s.rd; we = s.we; ld = s.ld; busy = s.busy; flush = s.flush; rst = s.rst;
  endtask

  task automatic step(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    drive(s);
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string fld, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h exp=%h", tag, fld, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, "pc_stall", 16'(pc_stall), 16'(mon_e.pcs));
      chk(mon_e.tag, "id_stall", 16'(id_stall), 16'(mon_e.ids));
      chk(mon_e.tag, "bubble",   16'(bubble),   16'(mon_e.bub));
      chk(mon_e.tag, "fwd1",     16'(f1),       16'(mon_e.f1));
      chk(mon_e.tag, "fwd2",     16'(f2),       16'(mon_e.f2));
      chk(mon_e.tag, "fwd3",     16'(f3),       16'(mon_e.f3));
      chk(mon_e.tag, "state",    16'(st),       16'(mon_e.st));
      chk(mon_e.tag, "cnt",      cnt,           mon_e.cnt);
    end
  end

  initial begin
    stim_t idle, bz;
    idle = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bz   = S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (2) @(posedge clk);

    step(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), E("rst",       0, 0, 0, 0, 0, 0, 0, 0));
    // load x5 followed by a consumer of x5
    step(S(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0), E("lu_prod",   0, 0, 0, 0, 0, 0, 0, 0));
    step(S(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0), E("lu_hit",    1, 1, 1, 5, 0, 0, 0, 0));
    step(S(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0), E("lu_retry",  0, 0, 0, 0, 5, 0, 1, 1));
    step(idle,                               E("lu_after",  0, 0, 0, 6, 0, 5, 0, 1));
    step(idle,                               E("drain1",    0, 0, 0, 0, 6, 0, 0, 1));
    step(idle,                               E("drain2",    0, 0, 0, 0, 0, 6, 0, 1));
    // load x0 and a consumer of x0
    step(S(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), E("x0_prod",   0, 0, 0, 0, 0, 0, 0, 1));
    step(S(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), E("x0_use",    0, 0, 0, 0, 0, 0, 0, 1));
    // four busy cycles with IS=x7, EX=x9
    step(S(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0), E("bz_pre1",   0, 0, 0, 0, 0, 0, 0, 1));
    step(S(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0), E("bz_pre2",   0, 0, 0, 9, 0, 0, 0, 1));
    step(S(1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0), E("busy1",     1, 1, 0, 7, 9, 0, 0, 1));
    step(S(1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0), E("busy2",     1, 1, 0, 7, 9, 0, 2, 2));
    step(S(1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0), E("busy3",     1, 1, 0, 7, 9, 0, 2, 3));
    step(S(1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0), E("busy4",     1, 1, 0, 7, 9, 0, 2, 4));
    step(S(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0), E("bz_exit",   0, 0, 0, 7, 9, 0, 2, 5));
    // flush with IS=x3, EX=x4
    step(S(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0), E("fl_pre1",   0, 0, 0, 8, 7, 9, 0, 5));
    step(S(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0), E("fl_pre2",   0, 0, 0, 4, 8, 7, 0, 5));
    step(S(1, 0, 0, 0, 0, 10, 1, 0, 0, 1, 0), E("flush",    0, 0, 1, 3, 4, 8, 0, 5));
    step(idle,                               E("fl_nxt",    0, 0, 0, 0, 0, 4, 3, 5));
    step(idle,                               E("fl_run",    0, 0, 0, 0, 0, 0, 0, 5));
    // flush coinciding with a load-use hazard
    step(S(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0), E("fllu_pre", 0, 0, 0, 0, 0, 0, 0, 5));
    step(S(1, 0, 0, 12, 1, 13, 1, 0, 0, 1, 0), E("fllu",    0, 0, 1, 12, 0, 0, 0, 5));
    step(idle,                               E("fllu_nxt",  0, 0, 0, 0, 0, 0, 3, 5));
    // flush arriving while BUSY
    step(S(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0), E("fb_pre",   0, 0, 0, 0, 0, 0, 0, 5));
    step(S(1, 0, 0, 0, 0, 15, 1, 0, 1, 0, 0), E("fb_busy",  1, 1, 0, 14, 0, 0, 0, 5));
    step(S(1, 0, 0, 0, 0, 15, 1, 0, 1, 1, 0), E("fb_flush", 0, 0, 1, 14, 0, 0, 2, 6));
    step(idle,                               E("fb_nxt",    0, 0, 0, 0, 0, 0, 3, 6));
    // reset in the middle of BUSY
    step(bz,                                 E("rb_busy",   1, 1, 0, 0, 0, 0, 0, 6));
    step(S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), E("rb_rst",    0, 0, 0, 0, 0, 0, 2, 7));
    step(idle,                               E("rb_after",  0, 0, 0, 0, 0, 0, 0, 0));
    // reset in the middle of LSTALL
    step(S(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0), E("rl_pre",    0, 0, 0, 0, 0, 0, 0, 0));
    step(S(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0), E("rl_hit",    1, 1, 1, 5, 0, 0, 0, 0));
    step(S(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1), E("rl_rst",    0, 0, 0, 0, 5, 0, 1, 1));
    step(idle,                               E("rl_after",  0, 0, 0, 0, 0, 0, 0, 0));
    // bring the counter to 16'hFFFE, then three more stall cycles
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
      #1;
      drive(bz);
    end
    step(bz,                                 E("sat1",      1, 1, 0, 0, 0, 0, 2, 16'hFFFE));
    step(bz,                                 E("sat2",      1, 1, 0, 0, 0, 0, 2, 16'hFFFF));
    step(bz,                                 E("sat3",      1, 1, 0, 0, 0, 0, 2, 16'hFFFF));
    step(idle,                               E("sat_exit",  0, 0, 0, 0, 0, 0, 2, 16'hFFFF));
    step(idle,                               E("sat_run",   0, 0, 0, 0, 0, 0, 0, 16'hFFFF));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
